// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: sequential unsigned magnitude comparator.
// Walks the latched operands MSB-first, one 2-bit slice per clock, and stops
// at the first unequal slice. Host handshake is start/busy/done; the result
// flags and the slice count stay registered until the next accepted start.
module comp_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int NS    = WIDTH / 2,
  localparam int CW    = $clog2(NS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb,
  output logic [CW-1:0]    slices
);

  // Slice index width; a single-slice operand still needs one index bit.
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_slices;
  logic             r_alb;
  logic             r_aeb;
  logic             r_agb;
  logic [1:0]       w_pa;
  logic [1:0]       w_pb;

  // Select the current 2-bit slice pair from the latched operands.
  always_comb begin
    w_pa = 2'b00;
    w_pb = 2'b00;
    for (int i = 0; i < NS; i++) begin
      if (r_idx == IW'(i)) begin
        w_pa = r_a[2*i +: 2];
        w_pb = r_b[2*i +: 2];
      end
    end
  end

  // Control FSM plus operand, index, count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_slices <= '0;
      r_alb    <= 1'b0;
      r_aeb    <= 1'b0;
      r_agb    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_idx    <= IW'(NS - 1);
            r_slices <= '0;
            r_alb    <= 1'b0;
            r_aeb    <= 1'b0;
            r_agb    <= 1'b0;
            r_state  <= S_CMP;
          end
        end
        S_CMP: begin
          r_slices <= r_slices + CW'(1);
          if (w_pa != w_pb) begin
            // First unequal slice decides the whole compare.
            r_alb   <= (w_pa < w_pb);
            r_agb   <= (w_pa > w_pb);
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            r_aeb   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_CMP);
  assign done   = (r_state == S_DONE);
  assign alb    = r_alb;
  assign aeb    = r_aeb;
  assign agb    = r_agb;
  assign slices = r_slices;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Bench for comp_seq_ctrl (WIDTH=8): vector table plus hand-written corner
// sequences. Expected results are queued at start time and retired when the
// DUT raises done.
module tb_comp_seq_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       alb;
    logic       aeb;
    logic       agb;
    logic [2:0] slices;
  } vec_t;

  typedef struct {
    logic       alb;
    logic       aeb;
    logic       agb;
    logic [2:0] slices;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       alb;
  logic       aeb;
  logic       agb;
  logic [2:0] slices;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  vec_t vt[9];

  comp_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .alb(alb), .aeb(aeb), .agb(agb),
    .slices(slices)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: slice count from the highest differing bit position.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb);
    exp_t       e;
    logic [7:0] x;
    int         hi;
    x  = ma ^ mb;
    hi = -1;
    for (int i = 0; i < 8; i++) if (x[i]) hi = i;
    e.alb    = (ma < mb);
    e.aeb    = (ma == mb);
    e.agb    = (ma > mb);
    e.slices = (hi < 0) ? 3'd4 : 3'(4 - hi / 2);
    e.acc    = 0;
    return e;
  endfunction

  // Result monitor: retire one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (rst !== 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alb", 32'(alb), 32'(e.alb));
        chk("aeb", 32'(aeb), 32'(e.aeb));
        chk("agb", 32'(agb), 32'(e.agb));
        chk("slices", 32'(slices), 32'(e.slices));
        chk("latency", 32'(cyc - e.acc), 32'(e.slices));
      end
    end
  end

  // Protocol invariants sampled every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("busy_done_overlap", 32'(busy & done), 32'd0);
      if (busy) chk("flags_while_busy", {29'd0, alb, aeb, agb}, 32'd0);
      if (done) chk("onehot_at_done", 32'(32'(alb) + 32'(aeb) + 32'(agb)), 32'd1);
    end
  end

  task automatic wait_empty(input string nm, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk({"timeout_", nm}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic hold_check(input string nm, input exp_t e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
      chk({nm, "_idle_done"}, 32'(done), 32'd0);
      chk({nm, "_held_flags"}, {29'd0, alb, aeb, agb}, {29'd0, e.alb, e.aeb, e.agb});
      chk({nm, "_held_slices"}, 32'(slices), 32'(e.slices));
    end
  endtask

  task automatic do_cmp(input string nm, input logic [7:0] ta, input logic [7:0] tb_, input exp_t e);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
    wait_empty(nm, 20);
    hold_check(nm, e, 5);
  endtask

  initial begin
    exp_t e;
    vt[0] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 3'd4};
    vt[1] = '{8'h40, 8'h3F, 1'b0, 1'b0, 1'b1, 3'd1};
    vt[2] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 3'd4};
    vt[3] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4};
    vt[4] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1};
    vt[5] = '{8'h0C, 8'h08, 1'b0, 1'b0, 1'b1, 3'd3};
    vt[6] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4};
    vt[7] = '{8'h00, 8'hC0, 1'b1, 1'b0, 1'b0, 3'd1};
    vt[8] = '{8'h35, 8'h36, 1'b1, 1'b0, 1'b0, 3'd4};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {25'd0, busy, done, alb, aeb, agb, slices}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      e.alb = vt[i].alb; e.aeb = vt[i].aeb; e.agb = vt[i].agb;
      e.slices = vt[i].slices; e.acc = 0;
      do_cmp($sformatf("vec%0d", i), vt[i].a, vt[i].b, e);
    end

    // Random vectors against the reference model
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (i % 2 == 0) ? (ra ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom);
      do_cmp($sformatf("rnd%0d", i), ra, rb, model(ra, rb));
    end

    // start while busy is ignored
    @(negedge clk);
    a = 8'h80; b = 8'h00; start = 1'b1;
    e = '{1'b0, 1'b0, 1'b1, 3'd1, cyc + 1};
    sb.push_back(e);
    @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_empty("busy_start", 10);
    hold_check("busy_start", e, 4);

    // Reset in the middle of a compare
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_async_clear", {25'd0, busy, done, alb, aeb, agb, slices}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    e = '{1'b0, 1'b1, 1'b0, 3'd4, 0};
    do_cmp("after_abort", 8'h03, 8'h03, e);

    // start held high: one done every 3 cycles
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = '{1'b0, 1'b0, 1'b1, 3'd1, cyc + 1 + 3 * k};
      sb.push_back(e);
    end
    wait_empty("held_start", 40);
    start = 1'b0;
    hold_check("held_start", e, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
